// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard receiver: conditions the pins, frames 11-bit PS/2 bytes and
// tracks the currently held key (make / F0 break / E0 extended) as an 8-bit keycode.
module ps2_keycode_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keycode,
  output logic       extended,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          dat_at_fall;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          byte_ok;
  logic          bad;
  logic          timeout;
  logic          brk_pend;
  logic          ext_pend;

  // Synchronizers and clock glitch filter; fall is a one-cycle pulse that
  // carries the data level captured on the very same cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_s1      <= 1'b0;
      clk_s2      <= 1'b0;
      dat_s1      <= 1'b0;
      dat_s2      <= 1'b0;
      clk_filt    <= 1'b0;
      filt_cnt    <= '0;
      fall        <= 1'b0;
      dat_at_fall <= 1'b0;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
      fall   <= 1'b0;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt    <= clk_s2;
        filt_cnt    <= '0;
        fall        <= clk_filt;
        dat_at_fall <= dat_s2;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    byte_ok    = 1'b0;
    bad        = 1'b0;
    timeout    = 1'b0;
    if (fall) begin
      case (state)
        S_IDLE: begin
          if (!dat_at_fall) state_next = S_DATA;
          else              bad        = 1'b1;
        end
        S_DATA: begin
          if (bit_cnt == 3'd7) state_next = S_PARITY;
        end
        S_PARITY: state_next = S_STOP;
        S_STOP: begin
          state_next = S_IDLE;
          if (dat_at_fall && (^{shift, par_bit})) byte_ok = 1'b1;
          else                                   bad     = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
    end else if (state != S_IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      timeout    = 1'b1;
      bad        = 1'b1;
      state_next = S_IDLE;
    end
  end

  // Frame datapath: shift register, bit counter, parity and inter-fall timeout.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      shift      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= byte_ok;
      frame_err  <= bad;
      if (byte_ok) byte_data <= shift;
      if (fall || state == S_IDLE || timeout) to_cnt <= '0;
      else                                    to_cnt <= to_cnt + TW'(1);
      if (state == S_IDLE) begin
        bit_cnt <= '0;
      end else if (fall && state == S_DATA) begin
        shift   <= {dat_at_fall, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end else if (fall && state == S_PARITY) begin
        par_bit <= dat_at_fall;
      end
    end
  end

  // Key tracking: prefixes only set pending flags; a break clears the key
  // only when it names the tracked key with the same extended flag.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      keycode  <= '0;
      extended <= 1'b0;
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
    end else if (byte_valid) begin
      if (byte_data == 8'hE0) begin
        ext_pend <= 1'b1;
      end else if (byte_data == 8'hF0) begin
        brk_pend <= 1'b1;
      end else begin
        if (!brk_pend) begin
          keycode  <= byte_data;
          extended <= ext_pend;
        end else if (byte_data == keycode && ext_pend == extended) begin
          keycode  <= 8'h00;
          extended <= 1'b0;
        end
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Bench for ps2_keycode_decoder: drives PS/2 frames on the pins, scoreboards
// received bytes and checks key tracking, frame errors, timeout and reset.
module tb_ps2_keycode_decoder;

  localparam int HALF = 20;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [7:0] keycode;
  logic       extended;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;

  int checks   = 0;
  int passes   = 0;
  int bv_seen  = 0;
  int err_seen = 0;
  int cyc      = 0;
  logic [7:0] exp_q[$];

  ps2_keycode_decoder dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .keycode   (keycode),
    .extended  (extended),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // clock / reset
  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc++;

  initial begin
    #1800000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // scoreboard: every good byte must match the head of exp_q
  always @(negedge CLOCK_50) begin
    logic [7:0] e;
    if (byte_valid === 1'b1) begin
      bv_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL byte_unexpected got=%h required=none", byte_data);
      end else begin
        e = exp_q.pop_front();
        if (byte_data !== e) $display("FAIL byte_data got=%h required=%h", byte_data, e);
        else passes++;
      end
    end
    if (frame_err === 1'b1) err_seen++;
  end

  // driver tasks
  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    repeat (HALF) @(posedge CLOCK_50);
    PS2_CLK = 1'b0;
    repeat (HALF) @(posedge CLOCK_50);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    if (!bad_par) exp_q.push_back(d);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ bad_par);
    ps2_bit(1'b1);
    PS2_DAT = 1'b1;
    repeat (2 * HALF) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    checks++; if (keycode !== 8'h00) $display("FAIL rst_keycode got=%h required=00", keycode); else passes++;
    checks++; if (extended !== 1'b0) $display("FAIL rst_extended got=%b required=0", extended); else passes++;
    checks++; if (byte_data !== 8'h00) $display("FAIL rst_byte_data got=%h required=00", byte_data); else passes++;
    checks++; if (byte_valid !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL rst_pulses got=%b%b required=00", byte_valid, frame_err); else passes++;
    reset = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    checks++; if (err_seen !== 0 || bv_seen !== 0)
      $display("FAIL rst_idle_pulses got=%0d/%0d required=0/0", bv_seen, err_seen); else passes++;
  endtask

  task automatic test_make_w;
    int n = 0;
    int b0 = bv_seen;
    fork
      send_frame(8'h1D, 1'b0);
    join_none
    @(negedge CLOCK_50);
    while (byte_valid !== 1'b1 && n < 2000) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      $display("FAIL make_w_timeout got=no_byte_valid required=byte_valid");
    end else begin
      passes++;
      checks++; if (keycode !== 8'h00) $display("FAIL make_w_early got=%h required=00", keycode); else passes++;
      @(negedge CLOCK_50);
      checks++; if (keycode !== 8'h1D) $display("FAIL make_w_keycode got=%h required=1d", keycode); else passes++;
      checks++; if (extended !== 1'b0) $display("FAIL make_w_ext got=%b required=0", extended); else passes++;
    end
    wait fork;
    checks++; if (bv_seen !== b0 + 1) $display("FAIL make_w_count got=%0d required=%0d", bv_seen - b0, 1); else passes++;
  endtask

  task automatic test_break;
    send_frame(8'h1D, 1'b0);
    checks++; if (keycode !== 8'h1D) $display("FAIL typematic got=%h required=1d", keycode); else passes++;
    send_frame(8'hF0, 1'b0);
    checks++; if (keycode !== 8'h1D) $display("FAIL break_prefix got=%h required=1d", keycode); else passes++;
    send_frame(8'h1D, 1'b0);
    checks++; if (keycode !== 8'h00) $display("FAIL break_release got=%h required=00", keycode); else passes++;
  endtask

  task automatic test_extended;
    send_frame(8'hE0, 1'b0);
    checks++; if (keycode !== 8'h00) $display("FAIL ext_prefix got=%h required=00", keycode); else passes++;
    send_frame(8'h75, 1'b0);
    checks++; if ({extended, keycode} !== 9'h175)
      $display("FAIL ext_make got=%b/%h required=1/75", extended, keycode); else passes++;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    checks++; if ({extended, keycode} !== 9'h000)
      $display("FAIL ext_break got=%b/%h required=0/00", extended, keycode); else passes++;
  endtask

  task automatic test_untracked_release;
    send_frame(8'h1C, 1'b0);
    checks++; if (keycode !== 8'h1C) $display("FAIL untracked_make got=%h required=1c", keycode); else passes++;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h23, 1'b0);
    checks++; if (keycode !== 8'h1C) $display("FAIL untracked_break got=%h required=1c", keycode); else passes++;
    send_frame(8'h23, 1'b0);
    checks++; if (keycode !== 8'h23) $display("FAIL untracked_next got=%h required=23", keycode); else passes++;
  endtask

  task automatic test_frame_errors;
    int e0 = err_seen;
    int b0 = bv_seen;
    int t_fall;
    int n = 0;
    logic [7:0] d = 8'h29;
    send_frame(8'h29, 1'b1);
    checks++; if (err_seen !== e0 + 1) $display("FAIL parity_err got=%0d required=1", err_seen - e0); else passes++;
    checks++; if (bv_seen !== b0) $display("FAIL parity_no_byte got=%0d required=0", bv_seen - b0); else passes++;
    checks++; if (keycode !== 8'h23) $display("FAIL parity_keycode got=%h required=23", keycode); else passes++;
    ps2_bit(1'b1);
    repeat (2 * HALF) @(negedge CLOCK_50);
    checks++; if (err_seen !== e0 + 2) $display("FAIL start_err got=%0d required=2", err_seen - e0); else passes++;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(d[i]);
    PS2_DAT = 1'b1;
    t_fall = cyc - HALF;
    @(negedge CLOCK_50);
    while (frame_err !== 1'b1 && n < 52000) begin
      @(negedge CLOCK_50);
      n++;
    end
    checks++;
    if (frame_err !== 1'b1 || cyc - t_fall < 50000 || cyc - t_fall > 50030)
      $display("FAIL timeout_err got=%0d cycles required=50000..50030", cyc - t_fall);
    else passes++;
    repeat (5) @(negedge CLOCK_50);
    checks++; if (bv_seen !== b0) $display("FAIL timeout_no_byte got=%0d required=0", bv_seen - b0); else passes++;
    send_frame(8'h29, 1'b0);
    checks++; if (keycode !== 8'h29) $display("FAIL after_timeout got=%h required=29", keycode); else passes++;
  endtask

  task automatic test_pending_across_error;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h44, 1'b1);
    send_frame(8'h29, 1'b0);
    checks++; if (keycode !== 8'h00) $display("FAIL pend_kept got=%h required=00", keycode); else passes++;
  endtask

  task automatic test_back_to_back;
    int b0 = bv_seen;
    exp_q.push_back(8'h1C);
    exp_q.push_back(8'h32);
    for (int f = 0; f < 2; f++) begin
      logic [7:0] d;
      d = (f == 0) ? 8'h1C : 8'h32;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(~^d);
      ps2_bit(1'b1);
    end
    PS2_DAT = 1'b1;
    repeat (2 * HALF) @(negedge CLOCK_50);
    checks++; if (keycode !== 8'h32) $display("FAIL last_wins got=%h required=32", keycode); else passes++;
    checks++; if (bv_seen !== b0 + 2) $display("FAIL b2b_count got=%0d required=2", bv_seen - b0); else passes++;
  endtask

  task automatic test_reset_mid_frame;
    int e0;
    int b0;
    send_frame(8'h12, 1'b0);
    checks++; if (keycode !== 8'h12) $display("FAIL pre_reset_key got=%h required=12", keycode); else passes++;
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    PS2_DAT = 1'b0;
    repeat (HALF) @(posedge CLOCK_50);
    PS2_CLK = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    checks++; if (keycode !== 8'h00 || extended !== 1'b0)
      $display("FAIL midrst_key got=%b/%h required=0/00", extended, keycode); else passes++;
    checks++; if (byte_data !== 8'h00 || byte_valid !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL midrst_outs got=%h/%b/%b required=00/0/0", byte_data, byte_valid, frame_err); else passes++;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    e0 = err_seen;
    b0 = bv_seen;
    reset = 1'b0;
    repeat (4 * HALF) @(negedge CLOCK_50);
    checks++; if (err_seen !== e0 || bv_seen !== b0)
      $display("FAIL midrst_pulses got=%0d/%0d required=0/0", bv_seen - b0, err_seen - e0); else passes++;
    send_frame(8'h12, 1'b0);
    checks++; if (keycode !== 8'h12) $display("FAIL post_reset_key got=%h required=12", keycode); else passes++;
  endtask

  initial begin
    test_reset();
    test_make_w();
    test_break();
    test_extended();
    test_untracked_release();
    test_frame_errors();
    test_pending_across_error();
    test_back_to_back();
    test_reset_mid_frame();
    checks++; if (exp_q.size() != 0) $display("FAIL bytes_missing got=%0d required=0", exp_q.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
